// File: rtl/hazard_resolver_param_pkg.sv
// Shared types and constants for the hazard resolver: state codes, timer width, parameter check.
package hazard_pkg;

    localparam int TMR_W = 3;

    typedef enum logic [2:0] {
        NORM   = 3'b000,
        SSTALL = 3'b010,
        FLUSH  = 3'b011,
        DSTALL = 3'b100
    } haz_state_t;

    // Timer is 3 bits and loads (latency - 1), so every latency must sit in 1..8.
    function automatic bit params_legal(input int reg_aw, input int load_lat, input int nofwd_lat,
                                        input int flush_cyc, input int cnt_w);
        return (reg_aw >= 1) && (cnt_w >= 1) &&
               (load_lat  >= 1) && (load_lat  <= 8) &&
               (nofwd_lat >= 1) && (nofwd_lat <= 8) &&
               (flush_cyc >= 1) && (flush_cyc <= 8);
    endfunction

endpackage

// File: rtl/hazard_resolver_param_if.sv
// Hazard resolver bundle: EX/ID operand info and hazard inputs in, stall/flush controls and counters out.
interface hazard_resolver_param_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8
);
    logic [REG_AW-1:0] ex_rd;
    logic              ex_rd_valid;
    logic              ex_is_load;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              fwd_en;
    logic              str;
    logic              br_mispredict;

    logic              pc_freeze;
    logic              if_id_hold;
    logic              bubble_ins;
    logic              do_flush;
    logic              resolved;
    logic [2:0]        state_out;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output ex_rd, ex_rd_valid, ex_is_load, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               fwd_en, str, br_mispredict,
        input  pc_freeze, if_id_hold, bubble_ins, do_flush, resolved, state_out,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ex_rd, ex_rd_valid, ex_is_load, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               fwd_en, str, br_mispredict,
        output pc_freeze, if_id_hold, bubble_ins, do_flush, resolved, state_out,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_resolver_param_raw_detect.sv
// RAW detector: ID sources vs EX destination; combinational, no state, no backpressure.
module haz_raw_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_rd_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              fwd_en,
    output logic              raw,
    output logic              dhaz
);
    logic match;

    assign match = (id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd));
    // x0 is hardwired, so a write to it never creates a dependency.
    assign raw   = ex_rd_valid && (ex_rd != '0) && match;
    assign dhaz  = raw && (ex_is_load || !fwd_en);
endmodule

// File: rtl/hazard_resolver_param.sv
// Hazard resolver: timed data stalls, structural stall, mispredict flush; Moore outputs, 1-cycle latency.
// No backpressure; emits stall/flush commands. HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_resolver_param
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int NOFWD_LAT = 2,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 8
) (
    input logic clk,
    input logic rst_n,
    hazard_resolver_param_if.slave hz
);
    if (!params_legal(REG_AW, LOAD_LAT, NOFWD_LAT, FLUSH_CYC, CNT_W)) begin : g_bad_param
        $error("hazard_resolver_param: latency parameters must be in 1..8");
    end

    localparam logic [TMR_W-1:0] LOAD_TMR  = TMR_W'(LOAD_LAT - 1);
    localparam logic [TMR_W-1:0] NOFWD_TMR = TMR_W'(NOFWD_LAT - 1);
    localparam logic [TMR_W-1:0] FLUSH_TMR = TMR_W'(FLUSH_CYC - 1);

    haz_state_t       state, state_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             flush_entry;
    logic             raw, dhaz;

    haz_raw_detect #(.REG_AW(REG_AW)) u_raw (
        .ex_rd       (hz.ex_rd),
        .ex_rd_valid (hz.ex_rd_valid),
        .ex_is_load  (hz.ex_is_load),
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_rs1_used (hz.id_rs1_used),
        .id_rs2_used (hz.id_rs2_used),
        .fwd_en      (hz.fwd_en),
        .raw         (raw),
        .dhaz        (dhaz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORM;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
        end
    end

    // Priority: mispredict > data > structural; FLUSH ignores all hazard inputs.
    always_comb begin
        state_nx    = state;
        tmr_nx      = tmr;
        flush_entry = 1'b0;
        case (state)
            NORM: begin
                if (hz.br_mispredict) begin
                    state_nx    = FLUSH;
                    tmr_nx      = FLUSH_TMR;
                    flush_entry = 1'b1;
                end else if (raw && dhaz) begin
                    state_nx = DSTALL;
                    tmr_nx   = hz.fwd_en ? LOAD_TMR : NOFWD_TMR;
                end else if (hz.str) begin
                    state_nx = SSTALL;
                end
            end
            DSTALL: begin
                if (hz.br_mispredict) begin
                    state_nx    = FLUSH;
                    tmr_nx      = FLUSH_TMR;
                    flush_entry = 1'b1;
                end else if (tmr == '0) begin
                    state_nx = NORM;
                end else begin
                    tmr_nx = tmr - TMR_W'(1);
                end
            end
            SSTALL: begin
                if (hz.br_mispredict) begin
                    state_nx    = FLUSH;
                    tmr_nx      = FLUSH_TMR;
                    flush_entry = 1'b1;
                end else if (!hz.str) begin
                    state_nx = NORM;
                end
            end
            FLUSH: begin
                if (tmr == '0) state_nx = NORM;
                else           tmr_nx   = tmr - TMR_W'(1);
            end
            default: state_nx = NORM;
        endcase
    end

    assign hz.pc_freeze  = (state == DSTALL) || (state == SSTALL) || (state == FLUSH);
    assign hz.if_id_hold = (state == DSTALL) || (state == SSTALL);
    assign hz.bubble_ins = (state == DSTALL) || (state == SSTALL);
    assign hz.do_flush   = (state == FLUSH);
    assign hz.resolved   = (state == NORM);
    assign hz.state_out  = state;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (((state == DSTALL) || (state == SSTALL)) && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (flush_entry && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
`else
    logic unused_flush_entry;
    assign unused_flush_entry = flush_entry;
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif
endmodule
